// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - dual H-bridge driver with soft-start/soft-stop PWM and reversal dead time
// Both sides share one free-running PWM counter; each side owns its ramp FSM.

module motor_pwm_side #(
    parameter int PWM_BITS     = 8,
    parameter int MAX_DUTY     = 255,
    parameter int RAMP_STEP    = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                period_start_i,
    input  logic [PWM_BITS-1:0] cnt_next_i,
    input  logic                en_i,
    input  logic                dir_i,
    output logic                in1_o,
    output logic                in2_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                busy_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UP   = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DEAD = 3'd4;

    localparam int DW = $clog2(DEAD_PERIODS + 2);
    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(RAMP_STEP);
    localparam logic [PWM_BITS:0] MAX_W  = (PWM_BITS+1)'(MAX_DUTY);

    logic [2:0]          state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                ldir_q, ldir_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic                in1_q, in2_q, busy_q;

    logic [PWM_BITS:0]   sum;
    logic [PWM_BITS-1:0] inc, dec;
    logic                hold, expire, pwm_d;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        ldir_d  = ldir_q;
        dead_d  = dead_q;
        sum     = {1'b0, duty_q} + STEP_W;
        inc     = (sum >= MAX_W) ? MAX_W[PWM_BITS-1:0] : sum[PWM_BITS-1:0];
        dec     = ({1'b0, duty_q} > STEP_W) ? duty_q - STEP_W[PWM_BITS-1:0] : '0;
        // A command is "held" only while it still matches the latched polarity.
        hold    = en_i && (dir_i == ldir_q);
        expire  = (32'(dead_q) + 32'd1 >= 32'(DEAD_PERIODS));

        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    ldir_d  = dir_i;
                    state_d = S_UP;
                end
            end
            S_UP: begin
                if (period_start_i) duty_d = inc;
                if (!hold)                                       state_d = S_DOWN;
                else if (period_start_i && inc == MAX_W[PWM_BITS-1:0]) state_d = S_RUN;
            end
            S_RUN: begin
                if (!hold) state_d = S_DOWN;
            end
            S_DOWN: begin
                if (period_start_i) duty_d = dec;
                if (hold) begin
                    state_d = S_UP;
                end else if (period_start_i && dec == '0) begin
                    state_d = S_DEAD;
                    dead_d  = '0;
                end
            end
            S_DEAD: begin
                if (period_start_i) begin
                    if (expire) begin
                        dead_d = '0;
                        if (en_i) begin
                            ldir_d  = dir_i;
                            state_d = S_UP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        dead_d = dead_q + DW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                duty_d  = '0;
            end
        endcase

        // Outputs are registered from next-state so they line up with the counter.
        pwm_d = cnt_next_i < duty_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            ldir_q  <= 1'b1;
            dead_q  <= '0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            ldir_q  <= ldir_d;
            dead_q  <= dead_d;
            in1_q   <= pwm_d & ldir_d;
            in2_q   <= pwm_d & ~ldir_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign in1_o  = in1_q;
    assign in2_o  = in2_q;
    assign duty_o = duty_q;
    assign busy_o = busy_q;
endmodule

module motor_pwm_driver #(
    parameter int PWM_BITS     = 8,
    parameter int MAX_DUTY     = 255,
    parameter int RAMP_STEP    = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                left_dir,
    input  logic                right_dir,
    input  logic                left_en,
    input  logic                right_en,
    output logic                left_in1,
    output logic                left_in2,
    output logic                right_in1,
    output logic                right_in2,
    output logic [PWM_BITS-1:0] left_duty,
    output logic [PWM_BITS-1:0] right_duty,
    output logic                left_busy,
    output logic                right_busy
);
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                period_start;

    assign cnt_d        = cnt_q + PWM_BITS'(1);
    assign period_start = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    motor_pwm_side #(
        .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY),
        .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
    ) u_left (
        .clk(clk), .rst(rst), .period_start_i(period_start), .cnt_next_i(cnt_d),
        .en_i(left_en), .dir_i(left_dir),
        .in1_o(left_in1), .in2_o(left_in2), .duty_o(left_duty), .busy_o(left_busy)
    );

    motor_pwm_side #(
        .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY),
        .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
    ) u_right (
        .clk(clk), .rst(rst), .period_start_i(period_start), .cnt_next_i(cnt_d),
        .en_i(right_en), .dir_i(right_dir),
        .in1_o(right_in1), .in2_o(right_in2), .duty_o(right_duty), .busy_o(right_busy)
    );
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - directed bench for motor_pwm_driver with a per-cycle reference model
// The model tracks each side as a phase plus integer duty and remaining dead periods.

module tb_motor_pwm_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left_dir = 1'b1, right_dir = 1'b1;
    logic       left_en = 1'b0, right_en = 1'b0;
    logic       left_in1, left_in2, right_in1, right_in2;
    logic [7:0] left_duty, right_duty;
    logic       left_busy, right_busy;

    int errors = 0;
    int checks = 0;

    motor_pwm_driver dut (
        .clk(clk), .rst(rst),
        .left_dir(left_dir), .right_dir(right_dir),
        .left_en(left_en), .right_en(right_en),
        .left_in1(left_in1), .left_in2(left_in2),
        .right_in1(right_in1), .right_in2(right_in2),
        .left_duty(left_duty), .right_duty(right_duty),
        .left_busy(left_busy), .right_busy(right_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    localparam int P_IDLE = 0, P_UP = 1, P_RUN = 2, P_DOWN = 3, P_DEAD = 4;

    typedef struct packed {
        logic [2:0] ph;
        int         duty;
        logic       ldir;
        int         dl;
    } side_t;

    function automatic side_t reset_side();
        side_t s;
        s.ph = 3'(P_IDLE); s.duty = 0; s.ldir = 1'b1; s.dl = 0;
        return s;
    endfunction

    function automatic side_t step(side_t s, logic ps, logic en, logic dir);
        side_t n;
        logic  keep;
        n    = s;
        keep = en && (dir == s.ldir);
        case (int'(s.ph))
            P_IDLE: if (en) begin n.ph = 3'(P_UP); n.ldir = dir; end
            P_UP: begin
                if (ps) n.duty = (s.duty + 16 > 255) ? 255 : s.duty + 16;
                if (!keep) n.ph = 3'(P_DOWN);
                else if (ps && n.duty == 255) n.ph = 3'(P_RUN);
            end
            P_RUN: if (!keep) n.ph = 3'(P_DOWN);
            P_DOWN: begin
                if (ps) n.duty = (s.duty < 16) ? 0 : s.duty - 16;
                if (keep) n.ph = 3'(P_UP);
                else if (ps && n.duty == 0) begin n.ph = 3'(P_DEAD); n.dl = 2; end
            end
            P_DEAD: if (ps) begin
                n.dl = s.dl - 1;
                if (n.dl == 0) begin
                    if (en) begin n.ph = 3'(P_UP); n.ldir = dir; end
                    else n.ph = 3'(P_IDLE);
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    side_t ml, mr;
    int    m_cnt = 0;
    bit    m_valid = 1'b0;
    bit    m_just_rst = 1'b0;
    int    pl_duty = 0, pr_duty = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt      <= 0;
            ml         <= reset_side();
            mr         <= reset_side();
            m_valid    <= 1'b1;
            m_just_rst <= 1'b1;
        end else begin
            m_cnt      <= (m_cnt + 1) % 256;
            ml         <= step(ml, m_cnt == 0, left_en, left_dir);
            mr         <= step(mr, m_cnt == 0, right_en, right_dir);
            m_just_rst <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("left_duty",  left_duty,  ml.duty);
            chk("left_busy",  left_busy,  int'(ml.ph != 3'(P_IDLE)));
            chk("left_in1",   left_in1,   int'(ml.ldir && (m_cnt < ml.duty)));
            chk("left_in2",   left_in2,   int'(!ml.ldir && (m_cnt < ml.duty)));
            chk("right_duty", right_duty, mr.duty);
            chk("right_busy", right_busy, int'(mr.ph != 3'(P_IDLE)));
            chk("right_in1",  right_in1,  int'(mr.ldir && (m_cnt < mr.duty)));
            chk("right_in2",  right_in2,  int'(!mr.ldir && (m_cnt < mr.duty)));
            chk("left_overlap",  int'(left_in1 & left_in2), 0);
            chk("right_overlap", int'(right_in1 & right_in2), 0);
            if (!m_just_rst) begin
                chk("left_duty_timing",  int'((int'(left_duty) != pl_duty) && m_cnt != 1), 0);
                chk("right_duty_timing", int'((int'(right_duty) != pr_duty) && m_cnt != 1), 0);
            end
            pl_duty <= int'(left_duty);
            pr_duty <= int'(right_duty);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_duty(string name, bit side, int val, int budget);
        int k = 0;
        while (int'(side ? right_duty : left_duty) != val && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, int'(side ? right_duty : left_duty), val);
    endtask

    task automatic wait_idle(string name, bit side, int budget);
        int k = 0;
        while ((side ? right_busy : left_busy) && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, int'(side ? right_busy : left_busy), 0);
    endtask

    task automatic count_pwm(bit side, output int c1, output int c2);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 256; i++) begin
            c1 += int'(side ? right_in1 : left_in1);
            c2 += int'(side ? right_in2 : left_in2);
            cyc(1);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, d1, d2;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        chk("reset_left_duty",  left_duty,  0);
        chk("reset_right_duty", right_duty, 0);
        chk("reset_left_busy",  left_busy,  0);
        chk("reset_left_in1",   left_in1,   0);

        // Forward soft start to RUN.
        left_dir = 1'b1;
        left_en  = 1'b1;
        wait_duty("fwd_first_step", 0, 16, 600);
        count_pwm(0, c1, c2);
        chk("fwd_in1_high_clocks", c1, 16);
        chk("fwd_in2_high_clocks", c2, 0);
        wait_duty("fwd_reach_max", 0, 255, 17 * 256);
        cyc(300);
        chk("fwd_run_hold", left_duty, 255);
        chk("fwd_run_busy", left_busy, 1);

        // Reversal: ramp down, dead interval, ramp up reverse.
        left_dir = 1'b0;
        wait_duty("rev_first_down", 0, 239, 300);
        wait_duty("rev_reach_zero", 0, 0, 17 * 256);
        count_pwm(0, c1, c2);
        count_pwm(0, d1, d2);
        chk("dead_inputs_low", c1 + c2 + d1 + d2, 0);
        chk("dead_busy", left_busy, 1);
        wait_duty("rev_first_up", 0, 16, 3 * 256);
        count_pwm(0, c1, c2);
        chk("rev_in1_high_clocks", c1, 0);
        chk("rev_in2_high_clocks", c2, 16);

        // Enable drop mid-ramp, resume without dead interval.
        wait_duty("drop_at_64", 0, 64, 5 * 256);
        left_en = 1'b0;
        wait_duty("down_to_32", 0, 32, 3 * 256);
        left_en = 1'b1;
        wait_duty("resume_48", 0, 48, 300);
        wait_duty("resume_64", 0, 64, 300);
        wait_duty("rev_reach_max", 0, 255, 17 * 256);

        // Reset while right is running.
        right_dir = 1'b1;
        right_en  = 1'b1;
        wait_duty("right_reach_max", 1, 255, 17 * 256 + 300);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_right_duty", right_duty, 0);
        chk("rst_right_busy", right_busy, 0);
        chk("rst_right_in1",  right_in1,  0);
        chk("rst_right_in2",  right_in2,  0);
        chk("rst_left_duty",  left_duty,  0);
        wait_duty("rst_restart_16", 1, 16, 600);

        // Single-clock enable pulse on right while left runs.
        wait_duty("left_rerun_max", 0, 255, 17 * 256);
        right_en = 1'b0;
        wait_idle("right_stop_idle", 1, 20 * 256);
        while (m_cnt != 255) cyc(1);
        right_en = 1'b1;
        cyc(1);
        right_en = 1'b0;
        cyc(1);
        chk("pulse_one_step", right_duty, 16);
        chk("pulse_busy", right_busy, 1);
        wait_duty("pulse_back_zero", 1, 0, 300);
        wait_idle("pulse_idle", 1, 4 * 256);
        chk("left_steady", left_duty, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Motor-side endpoint for the rover's motor command interface. Consumes the per-side direction and enable commands produced by the line-following motor controller and drives two H-bridge channels (left, right) with soft-start/soft-stop PWM. Every direction reversal is separated by a dead interval, so the bridge never goes straight from one polarity to the other. Sits between the motor controller and the H-bridge input pins.

## Interface
- `PWM_BITS`, 8: PWM counter width. PWM period is 2^PWM_BITS clocks.
- `MAX_DUTY`, 255: full-run duty. Must be ≤ 2^PWM_BITS − 1.
- `RAMP_STEP`, 16: duty change applied per PWM period while ramping.
- `DEAD_PERIODS`, 2: whole PWM periods with both bridge inputs low before re-energising.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `left_dir`  in  1  left command direction: 1 = forward, 0 = reverse.
- `right_dir`  in  1  right command direction.
- `left_en`  in  1  left motor enable command.
- `right_en`  in  1  right motor enable command.
- `left_in1`, `left_in2`  out  1 each  left H-bridge inputs (forward, reverse).
- `right_in1`, `right_in2`  out  1 each  right H-bridge inputs.
- `left_duty`, `right_duty`  out  PWM_BITS each  current applied duty (status).
- `left_busy`, `right_busy`  out  1 each  high in any state other than IDLE.

## Operation
- One shared, free-running PWM counter `cnt`, PWM_BITS wide. Increments every clock and wraps from 2^PWM_BITS − 1 to 0. A *period start* is the cycle where `cnt == 0`.
- Per-side PWM level: `pwm = (cnt < duty)`.
  - Latched direction forward: `in1 = pwm`, `in2 = 0`.
  - Latched direction reverse: `in1 = 0`, `in2 = pwm`.
  - `duty == 0` drives both inputs low (coast).
- Each side has its own identical FSM with states IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD. Each side also keeps a latched direction `ldir` and a dead-period counter.
- **IDLE**: duty 0.
  - `en = 1`: latch `ldir ← dir`, go to RAMP_UP.
- **RAMP_UP**: at each period start, `duty ← min(duty + RAMP_STEP, MAX_DUTY)`. Compute the sum at PWM_BITS+1 bits, then saturate.
  - Reaching MAX_DUTY: go to RUN.
  - `en = 0`, or `dir != ldir`: go to RAMP_DOWN.
- **RUN**: duty = MAX_DUTY.
  - `en = 0`, or `dir != ldir`: go to RAMP_DOWN.
- **RAMP_DOWN**: at each period start, `duty ← duty − RAMP_STEP`, saturating at 0.
  - Duty reaches 0: go to DEAD.
  - `en = 1` and `dir == ldir`: go to RAMP_UP, resuming from the current duty with no dead interval.
- **DEAD**: duty 0, both bridge inputs 0. Counts DEAD_PERIODS period starts, then:
  - `en = 1`: latch `ldir ← dir`, go to RAMP_UP.
  - Otherwise: go to IDLE.
  - Changes on `en` or `dir` during DEAD are ignored until the count expires.
- Simultaneous `en` drop and `dir` change: treated as an enable drop (RAMP_DOWN). On the next enable, the direction is latched only after passing through DEAD.
- Invariant: `in1 & in2 == 0` on both sides at all times.
- Left and right sides are fully independent; they share only `cnt`.

## Timing
- Reset (synchronous, takes effect at the clock edge with `rst = 1`):
  - `cnt = 0`; both FSMs in IDLE; duty 0; `ldir = 1`; dead counters 0.
  - All `*_in*`, `*_duty` and `*_busy` outputs are 0 one clock after the reset edge.
  - Reset mid-operation aborts any ramp immediately; there is no soft stop.
- All outputs are registered.
- Command inputs are sampled every clock. State transitions caused by `en`/`dir` take effect on the next clock edge.
- Duty updates and DEAD counting occur only at period starts, so duty never changes mid-period.
- Enable latency: `en` asserted at edge t gives RAMP_UP at t+1. The first nonzero duty is applied at the next period start.
- Full ramp with defaults: 0 → 255 takes 16 period starts (16·16 = 256, saturates to 255) = 4096 clocks. The full ramp down takes the same.
- Reversal from RUN with defaults: 16 ramp-down periods, then 2 dead periods, then ramp up in the new direction.

## Test plan
- Reset, then `left_en = 1`, `left_dir = 1` → `left_duty` steps 16, 32, …, 240, 255 at successive period starts, then RUN. `left_in1` is high for exactly `duty` clocks per period; `left_in2` stays 0 throughout.
- In RUN, flip `left_dir` to 0 → duty ramps 255, 239, …, 15, 0. Both inputs are then low for 2 full periods. `left_in2` then ramps 16, 32, …, and `left_in1` stays 0.
- `left_en` drops at duty 64 (RAMP_UP). Re-assert `left_en` with the same direction when duty = 32 → duty resumes 48, 64, … with no dead interval.
- Assert `rst` for one cycle while right is in RUN → all right outputs 0 on the next clock and state IDLE. After `rst` deasserts with `right_en` still high, the right side restarts from duty 16.
- Left in RUN while right is idle; toggle `right_en` for one clock → right ramps up one step, then down to 0, then DEAD → IDLE. Left duty stays at 255 throughout.
- Continuous checkers over all scenarios:
  - `in1 & in2` is never 1 on either side.
  - Duty changes only in the cycle following `cnt == 0`.
  - `busy` = 0 exactly when the side is in IDLE.
